// File: rtl/riscv_dbg_pkg.sv
// Shared definitions for the RV_CPU out-port monitor and its consumers.
// The event record layout lives here so every decoder reads the same fields.
package riscv_dbg_pkg;

    localparam int unsigned OUT_WIDTH     = 10;
    localparam int unsigned EVT_TS_WIDTH  = 16;
    localparam int unsigned FIFO_DEPTH    = 8;
    localparam int unsigned OVF_CNT_WIDTH = 8;

    localparam int unsigned EVT_DATA_LSB = 0;
    localparam int unsigned EVT_TS_LSB   = OUT_WIDTH;
    localparam int unsigned EVT_WIDTH    = EVT_TS_WIDTH + OUT_WIDTH;

    // Event record as stored in the FIFO: timestamp in the upper bits
    typedef struct packed {
        logic [EVT_TS_WIDTH-1:0] ts;
        logic [OUT_WIDTH-1:0]    data;
    } out_evt_t;

endpackage

// File: rtl/riscv_out_monitor_if.sv
// Valid/ready event stream from the monitor to its consumer.
interface riscv_out_monitor_if
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned WIDTH    = OUT_WIDTH,
    parameter int unsigned TS_WIDTH = EVT_TS_WIDTH
) ();

    logic                m_valid;
    logic                m_ready;
    logic [WIDTH-1:0]    m_data;
    logic [TS_WIDTH-1:0] m_ts;

    modport master (output m_valid, output m_data, output m_ts, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_ts, output m_ready);

endinterface

// File: rtl/riscv_out_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_cnt_q, wr_cnt_d;
    logic [PW:0]      rd_cnt_q, rd_cnt_d;
    logic             do_push_c, do_pop_c;

    // Counters carry one extra bit so full and empty stay distinguishable
    assign level_o = wr_cnt_q - rd_cnt_q;
    assign valid_o = (level_o != '0);
    assign full_o  = (level_o == (PW+1)'(DEPTH));
    assign rdata_o = mem_q[rd_cnt_q[PW-1:0]];

    always_comb begin
        do_pop_c  = pop_i & valid_o & ~clear_i;
        do_push_c = push_i & ~clear_i & (~full_o | do_pop_c);
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (clear_i) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            if (do_push_c) wr_cnt_d = wr_cnt_q + (PW+1)'(1);
            if (do_pop_c)  rd_cnt_d = rd_cnt_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push_c) begin
            mem_q[wr_cnt_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/riscv_out_monitor.sv
// Timestamps every change of the RV_CPU out port, buffers the events and
// streams them out, counting events lost to a full buffer.
module riscv_out_monitor
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned WIDTH     = OUT_WIDTH,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned TS_WIDTH  = EVT_TS_WIDTH,
    parameter int unsigned OVF_WIDTH = OVF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         cpu_out,
    riscv_out_monitor_if.master      m_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_flag,
    output logic [OVF_WIDTH-1:0]     ovf_count
);

    localparam int unsigned EW = TS_WIDTH + WIDTH;

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [WIDTH-1:0]     prev_q;
    logic                 primed_q;
    logic [OVF_WIDTH-1:0] ovf_count_q, ovf_count_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic                 evt_c, pop_c, push_c, drop_c, full_c;
    logic [EW-1:0]        rec_c, head_c;

    // Records carry the count of the capturing edge: first edge after reset is 1
    always_comb begin
        ts_d        = ts_q + TS_WIDTH'(1);
        evt_c       = enable & (~primed_q | (cpu_out != prev_q));
        pop_c       = m_if.m_valid & m_if.m_ready;
        push_c      = evt_c & ~clear & (~full_c | pop_c);
        drop_c      = evt_c & ~clear & full_c & ~pop_c;
        rec_c       = {ts_d, cpu_out};
        ovf_count_d = ovf_count_q;
        ovf_flag_d  = ovf_flag_q;
        if (clear) begin
            ovf_count_d = '0;
            ovf_flag_d  = 1'b0;
        end else if (drop_c) begin
            ovf_flag_d = 1'b1;
            if (ovf_count_q != '1) ovf_count_d = ovf_count_q + OVF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q        <= '0;
            prev_q      <= '0;
            primed_q    <= 1'b0;
            ovf_count_q <= '0;
            ovf_flag_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            prev_q      <= cpu_out;
            primed_q    <= 1'b1;
            ovf_count_q <= ovf_count_d;
            ovf_flag_q  <= ovf_flag_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (clear),
        .push_i  (push_c),
        .wdata_i (rec_c),
        .pop_i   (pop_c),
        .rdata_o (head_c),
        .valid_o (m_if.m_valid),
        .full_o  (full_c),
        .level_o (level)
    );

    assign m_if.m_ts   = head_c[EW-1:WIDTH];
    assign m_if.m_data = head_c[WIDTH-1:0];
    assign ovf_flag    = ovf_flag_q;
    assign ovf_count   = ovf_count_q;

endmodule

// File: tb/tb_riscv_out_monitor.sv
// Self-checking bench for riscv_out_monitor: a behavioural model fills a
// scoreboard queue as events are captured; tasks compare the stream against it.
module tb_riscv_out_monitor;
    import riscv_dbg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic [9:0] cpu_out;
    logic [3:0] level;
    logic       ovf_flag;
    logic [7:0] ovf_count;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_out_monitor_if mif ();

    riscv_out_monitor dut (
        .clk       (clk),
        .reset     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .cpu_out   (cpu_out),
        .m_if      (mif.master),
        .level     (level),
        .ovf_flag  (ovf_flag),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scoreboard of entries expected to be in the FIFO
    out_evt_t    exp_q[$];
    logic [15:0] mdl_ts;
    logic [9:0]  mdl_prev;
    logic        mdl_primed;
    logic [7:0]  mdl_ovf;
    logic        mdl_flag;

    always @(posedge clk or negedge rst_n) begin : model
        logic        ev, pop, full;
        logic [15:0] stamp;
        if (!rst_n) begin
            exp_q.delete();
            mdl_ts = '0; mdl_prev = '0; mdl_primed = 1'b0; mdl_ovf = '0; mdl_flag = 1'b0;
        end else begin
            ev    = enable && (!mdl_primed || cpu_out != mdl_prev);
            stamp = mdl_ts + 16'd1;
            if (clear) begin
                exp_q.delete();
                mdl_ovf = '0; mdl_flag = 1'b0;
            end else begin
                pop  = (exp_q.size() > 0) && (mif.m_ready === 1'b1);
                full = (exp_q.size() == FIFO_DEPTH);
                if (pop) void'(exp_q.pop_front());
                if (ev) begin
                    if (full && !pop) begin
                        mdl_flag = 1'b1;
                        if (mdl_ovf != 8'hFF) mdl_ovf = mdl_ovf + 8'd1;
                    end else begin
                        exp_q.push_back({stamp, cpu_out});
                    end
                end
            end
            mdl_prev = cpu_out; mdl_primed = 1'b1; mdl_ts = stamp;
        end
    end

    // Pops every expected entry, comparing the head each cycle; bounded wait
    task automatic drain(input string name);
        int guard = 0;
        mif.m_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 4 * FIFO_DEPTH) begin
            n_chk++;
            if (mif.m_valid !== 1'b1 || mif.m_data !== exp_q[0].data || mif.m_ts !== exp_q[0].ts) begin
                n_fail++;
                $display("FAIL %s_head: got v=%b d=%h ts=%0d, expected v=1 d=%h ts=%0d",
                         name, mif.m_valid, mif.m_data, mif.m_ts, exp_q[0].data, exp_q[0].ts);
            end
            @(negedge clk);
            guard++;
        end
        mif.m_ready = 1'b0;
        n_chk++;
        if (exp_q.size() != 0 || mif.m_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_empty: got v=%b level=%0d left=%0d, expected v=0 level=0 left=0",
                     name, mif.m_valid, level, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; cpu_out = 10'h000; mif.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (mif.m_valid !== 1'b0 || level !== 4'd0 || ovf_flag !== 1'b0 || ovf_count !== 8'd0 ||
            mif.m_data !== 10'h000 || mif.m_ts !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_vals: got v=%b lvl=%0d flag=%b cnt=%0d d=%h ts=%0d, expected all 0",
                     mif.m_valid, level, ovf_flag, ovf_count, mif.m_data, mif.m_ts);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mif.m_valid !== 1'b1 || level !== 4'd1 || mif.m_data !== 10'h000 || mif.m_ts !== 16'd1) begin
            n_fail++;
            $display("FAIL initial_event: got v=%b lvl=%0d d=%h ts=%0d, expected v=1 lvl=1 d=000 ts=1",
                     mif.m_valid, level, mif.m_data, mif.m_ts);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (level !== 4'd1) begin
            n_fail++;
            $display("FAIL constant_no_event: got level=%0d, expected 1", level);
        end
        drain("reset");
    endtask

    task automatic test_consecutive();
        logic [15:0] t0;
        mif.m_ready = 1'b1;
        cpu_out = 10'h001;
        @(negedge clk);
        t0 = mif.m_ts;
        n_chk++;
        if (mif.m_valid !== 1'b1 || mif.m_data !== 10'h001 || exp_q.size() != 1 || t0 !== exp_q[0].ts) begin
            n_fail++;
            $display("FAIL consec_first: got v=%b d=%h ts=%0d, expected v=1 d=001 ts=%0d",
                     mif.m_valid, mif.m_data, t0, (exp_q.size() != 0) ? exp_q[0].ts : 16'hFFFF);
        end
        for (int i = 2; i <= 3; i++) begin
            cpu_out = 10'(i);
            @(negedge clk);
            n_chk++;
            if (mif.m_valid !== 1'b1 || mif.m_data !== 10'(i) || mif.m_ts !== t0 + 16'(i - 1) || level !== 4'd1) begin
                n_fail++;
                $display("FAIL consec_%0d: got v=%b d=%h ts=%0d lvl=%0d, expected v=1 d=%h ts=%0d lvl=1",
                         i, mif.m_valid, mif.m_data, mif.m_ts, level, 10'(i), t0 + 16'(i - 1));
            end
        end
        drain("consec");
    endtask

    task automatic test_overflow();
        mif.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_out = 10'h010 + 10'(i);
            @(negedge clk);
        end
        n_chk++;
        if (level !== 4'd8 || ovf_count !== 8'd2 || ovf_flag !== 1'b1 || mif.m_data !== 10'h010) begin
            n_fail++;
            $display("FAIL overflow: got lvl=%0d cnt=%0d flag=%b head=%h, expected lvl=8 cnt=2 flag=1 head=010",
                     level, ovf_count, ovf_flag, mif.m_data);
        end
    endtask

    task automatic test_full_pop_push();
        cpu_out = 10'h01A;
        mif.m_ready = 1'b1;
        @(negedge clk);
        mif.m_ready = 1'b0;
        n_chk++;
        if (level !== 4'd8 || ovf_count !== 8'd2 || mif.m_data !== 10'h011) begin
            n_fail++;
            $display("FAIL full_pop_push: got lvl=%0d cnt=%0d head=%h, expected lvl=8 cnt=2 head=011",
                     level, ovf_count, mif.m_data);
        end
        drain("full_drain");
    endtask

    task automatic test_enable_off();
        enable = 1'b0;
        cpu_out = 10'h005;
        @(negedge clk);
        cpu_out = 10'h006;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (mif.m_valid !== 1'b0 || level !== 4'd0 || ovf_count !== 8'd2) begin
            n_fail++;
            $display("FAIL enable_off: got v=%b lvl=%0d cnt=%0d, expected v=0 lvl=0 cnt=2",
                     mif.m_valid, level, ovf_count);
        end
    endtask

    task automatic test_reset_mid_and_clear();
        mif.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_out = 10'h020 + 10'(i);
            @(negedge clk);
        end
        n_chk++;
        if (level !== 4'd5) begin
            n_fail++;
            $display("FAIL pre_reset_level: got %0d, expected 5", level);
        end
        mif.m_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if (mif.m_valid !== 1'b0 || level !== 4'd0 || ovf_count !== 8'd0 || ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b lvl=%0d cnt=%0d flag=%b, expected all 0",
                     mif.m_valid, level, ovf_count, ovf_flag);
        end
        @(negedge clk);
        rst_n = 1'b1; mif.m_ready = 1'b0; cpu_out = 10'h0AB;
        @(negedge clk);
        n_chk++;
        if (level !== 4'd1 || mif.m_data !== 10'h0AB || mif.m_ts !== 16'd1) begin
            n_fail++;
            $display("FAIL relog_initial: got lvl=%0d d=%h ts=%0d, expected lvl=1 d=0ab ts=1",
                     level, mif.m_data, mif.m_ts);
        end
        for (int i = 0; i < 8; i++) begin
            cpu_out = 10'h030 + 10'(i);
            @(negedge clk);
        end
        n_chk++;
        if (level !== 4'd8 || ovf_count !== 8'd1 || ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL refill: got lvl=%0d cnt=%0d flag=%b, expected lvl=8 cnt=1 flag=1",
                     level, ovf_count, ovf_flag);
        end
        clear = 1'b1; cpu_out = 10'h040;
        @(negedge clk);
        clear = 1'b0;
        n_chk++;
        if (level !== 4'd0 || mif.m_valid !== 1'b0 || ovf_count !== 8'd0 || ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_with_change: got lvl=%0d v=%b cnt=%0d flag=%b, expected all 0",
                     level, mif.m_valid, ovf_count, ovf_flag);
        end
        @(negedge clk);
        n_chk++;
        if (level !== 4'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_clear_idle: got lvl=%0d, expected 0", level);
        end
    endtask

    initial begin
        test_reset();
        test_consecutive();
        test_overflow();
        test_full_pop_push();
        test_enable_off();
        test_reset_mid_and_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
